// File: rtl/parser.sv
// Streaming message parser: assembles header + payload words into one
// 296-bit record per message and flags per-stream sequence gaps.
module parser #(
  parameter int STREAM_ENTRIES    = 8,
  parameter int MAX_PAYLOAD_BYTES = 30
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [31:0]  dataIn,
  input  logic         dataIn_val,
  output logic         dataIn_ready,
  input  logic         dataIN_last,
  output logic [0:295] dataOut,
  output logic         dataOut_val,
  input  logic         dataOut_ready,
  output logic         packetLost
);

  localparam int PW  = 8 * MAX_PAYLOAD_BYTES;
  localparam int CW  = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int PSW = CW + 1;
  localparam int IW  = (STREAM_ENTRIES > 1) ? $clog2(STREAM_ENTRIES) : 1;

  typedef enum logic [1:0] {HDR, SEQ, PAY, PEND} state_t;

  state_t          state, state_n;
  logic [1:0]      tail, tail_n;      // L mod 4, sizes the last word
  logic [15:0]     sid, sid_n;
  logic [31:0]     seq, seq_n;
  logic [CW-1:0]   cap, cap_n;        // min(L-8, MAX_PAYLOAD_BYTES)
  logic [CW-1:0]   rcv, rcv_n;        // payload bytes stored so far
  logic            bad, bad_n;        // header length below 8
  logic [0:PW-1]   pay, pay_n;        // byte k at [8k +: 8]

  logic            acc, out_free, done, load;
  logic [15:0]     hdr_len, len_m8;
  logic [2:0]      nvalid;
  logic [PSW-1:0]  pos, sum;

  // stream table
  logic [STREAM_ENTRIES-1:0] tab_vld;
  logic [15:0]     tab_sid [STREAM_ENTRIES];
  logic [31:0]     tab_seq [STREAM_ENTRIES];
  logic [IW-1:0]   rr;
  logic            hit, free;
  logic [IW-1:0]   hit_idx, free_idx, widx;
  logic            lost_c;

  assign dataIn_ready = (state != PEND);
  assign acc          = dataIn_val && dataIn_ready;
  assign out_free     = !dataOut_val || dataOut_ready;

  // Next-state and message assembly: header decode, payload byte packing,
  // and the decision to load the output register or park in PEND.
  always_comb begin
    state_n = state;
    tail_n  = tail;
    sid_n   = sid;
    seq_n   = seq;
    cap_n   = cap;
    rcv_n   = rcv;
    bad_n   = bad;
    pay_n   = pay;
    done    = 1'b0;
    load    = 1'b0;
    hdr_len = {dataIn[23:16], dataIn[31:24]};
    len_m8  = hdr_len - 16'd8;
    nvalid  = 3'd4;
    pos     = '0;
    sum     = '0;
    case (state)
      HDR: if (acc) begin
        tail_n = hdr_len[1:0];
        sid_n  = {dataIn[7:0], dataIn[15:8]};
        bad_n  = (hdr_len < 16'd8);
        if (hdr_len < 16'd8)
          cap_n = '0;
        else if (len_m8 >= 16'(MAX_PAYLOAD_BYTES))
          cap_n = CW'(MAX_PAYLOAD_BYTES);
        else
          cap_n = len_m8[CW-1:0];
        rcv_n  = '0;
        pay_n  = '0;
        // a message ending on its first word is dropped outright
        state_n = dataIN_last ? HDR : SEQ;
      end
      SEQ: if (acc) begin
        seq_n   = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
        state_n = PAY;
        done    = dataIN_last;
      end
      PAY: if (acc) begin
        if (dataIN_last)
          nvalid = (tail == 2'd0) ? 3'd4 : {1'b0, tail};
        for (int b = 0; b < 4; b++) begin
          pos = {1'b0, rcv} + PSW'(b);
          if (3'(b) < nvalid && pos < {1'b0, cap})
            pay_n[8*pos +: 8] = dataIn[31-8*b -: 8];
        end
        sum   = {1'b0, rcv} + PSW'(nvalid);
        rcv_n = (sum > {1'b0, cap}) ? cap : sum[CW-1:0];
        done  = dataIN_last;
      end
      PEND: if (out_free) begin
        load    = 1'b1;
        state_n = HDR;
      end
      default: state_n = HDR;
    endcase
    if (done) begin
      if (bad)
        state_n = HDR;
      else if (out_free) begin
        load    = 1'b1;
        state_n = HDR;
      end else
        state_n = PEND;
    end
  end

  // Table lookup for the record being loaded: hit, first free slot, victim.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < STREAM_ENTRIES; i++) begin
      if (!hit && tab_vld[i] && tab_sid[i] == sid_n) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free && !tab_vld[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
    widx   = hit ? hit_idx : (free ? free_idx : rr);
    lost_c = hit && (seq_n != tab_seq[hit_idx] + 32'd1);
  end

  // Assembly state registers.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state <= HDR;
      tail  <= '0;
      sid   <= '0;
      seq   <= '0;
      cap   <= '0;
      rcv   <= '0;
      bad   <= 1'b0;
      pay   <= '0;
    end else begin
      state <= state_n;
      tail  <= tail_n;
      sid   <= sid_n;
      seq   <= seq_n;
      cap   <= cap_n;
      rcv   <= rcv_n;
      bad   <= bad_n;
      pay   <= pay_n;
    end
  end

  // Stream table update happens only when a record is actually loaded.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      tab_vld <= '0;
      rr      <= '0;
    end else if (load) begin
      tab_vld[widx] <= 1'b1;
      tab_sid[widx] <= sid_n;
      tab_seq[widx] <= seq_n;
      if (!hit && !free)
        rr <= (rr == IW'(STREAM_ENTRIES - 1)) ? '0 : rr + 1'b1;
    end
  end

  // Output record register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      dataOut     <= '0;
      dataOut_val <= 1'b0;
      packetLost  <= 1'b0;
    end else if (load) begin
      dataOut     <= {sid_n, seq_n, 8'(rcv_n), pay_n};
      dataOut_val <= 1'b1;
      packetLost  <= lost_c;
    end else if (dataOut_ready) begin
      dataOut_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parser.sv
// Directed + randomized bench for parser with a message-level reference model.
module tb_parser;

  logic         clk = 1'b0;
  logic         reset_b;
  logic [31:0]  dataIn;
  logic         dataIn_val;
  logic         dataIn_ready;
  logic         dataIN_last;
  logic [0:295] dataOut;
  logic         dataOut_val;
  logic         dataOut_ready;
  logic         packetLost;

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b0;
  logic [7:0]  pbytes[$];
  logic [31:0] seen[int];

  parser dut (
    .clk(clk), .reset_b(reset_b), .dataIn(dataIn), .dataIn_val(dataIn_val),
    .dataIn_ready(dataIn_ready), .dataIN_last(dataIN_last), .dataOut(dataOut),
    .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready), .packetLost(packetLost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [295:0] obs, input logic [295:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one word; waits (bounded) for ready, returns 1 time unit after the accepting edge
  task automatic send_word(input logic [31:0] w, input bit last);
    int n = 0;
    @(negedge clk);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    dataIn = w; dataIn_val = 1'b1; dataIN_last = last;
    while (!dataIn_ready && n < 200) begin @(negedge clk); n++; end
    if (!dataIn_ready) check("ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    dataIn_val = 1'b0; dataIN_last = 1'b0;
  endtask

  // full message; payload bytes in wire order are left in pbytes
  task automatic send_msg(input logic [15:0] s, input logic [31:0] q, input logic [15:0] l, input bit rnd);
    logic [31:0] w;
    int npw;
    pbytes.delete();
    npw = (l > 16'd8) ? (int'(l) - 8 + 3) / 4 : 0;
    send_word({l[7:0], l[15:8], s[7:0], s[15:8]}, 1'b0);
    send_word({q[7:0], q[15:8], q[23:16], q[31:24]}, npw == 0);
    for (int i = 0; i < npw; i++) begin
      w = rnd ? $urandom : (32'(s) << 24) + (32'(q) << 16) + (32'(l) << 8) + 32'(i + 2);
      for (int b = 0; b < 4; b++) pbytes.push_back(w[31-8*b -: 8]);
      send_word(w, i == npw - 1);
    end
  endtask

  function automatic logic [295:0] exp_rec(input logic [15:0] s, input logic [31:0] q, input logic [15:0] l);
    int cnt;
    logic [239:0] p;
    cnt = (int'(l) - 8 > 30) ? 30 : int'(l) - 8;
    p = '0;
    for (int k = 0; k < cnt; k++) p[239-8*k -: 8] = pbytes[k];
    return {s, q, 8'(cnt), p};
  endfunction

  function automatic bit model_lost(input logic [15:0] s, input logic [31:0] q);
    bit r;
    r = seen.exists(int'(s)) && (q != seen[int'(s)] + 32'd1);
    seen[int'(s)] = q;
    return r;
  endfunction

  task automatic expect_rec(input string tag, input logic [15:0] s, input logic [31:0] q, input logic [15:0] l);
    logic [295:0] e;
    bit el;
    e  = exp_rec(s, q, l);
    el = model_lost(s, q);
    check({tag, "_val"}, dataOut_val, 1'b1);
    check({tag, "_rec"}, dataOut, e);
    check({tag, "_lost"}, packetLost, el);
  endtask

  task automatic consume();
    @(negedge clk); dataOut_ready = 1'b1;
    @(posedge clk); #1; dataOut_ready = 1'b0;
  endtask

  initial begin
    logic [15:0]  s, l;
    logic [31:0]  q;
    logic [295:0] e2, held;
    bit           el2;

    reset_b = 1'b1; dataIn = '0; dataIn_val = 1'b0; dataIN_last = 1'b0; dataOut_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", dataOut, '0);
    check("rst_val", dataOut_val, 1'b0);
    check("rst_lost", packetLost, 1'b0);
    check("rst_ready", dataIn_ready, 1'b1);
    @(negedge clk); reset_b = 1'b0;

    // first record, one cycle after last word, with literal field checks
    send_msg(16'd12, 32'd1, 16'd20, 1'b0);
    expect_rec("m1", 16'd12, 32'd1, 16'd20);
    check("m1_sid", dataOut[0:15], 16'h000C);
    check("m1_seq", dataOut[16:47], 32'h1);
    check("m1_cnt", dataOut[48:55], 8'h0C);
    check("m1_pay", dataOut[56:151], 96'h0C011402_0C011403_0C011404);
    check("m1_zero", dataOut[152:295], '0);
    held = dataOut;
    repeat (3) @(posedge clk);
    #1;
    check("m1_hold_val", dataOut_val, 1'b1);
    check("m1_hold_rec", dataOut, held);

    // second message while output is stalled -> PEND
    send_msg(16'd13, 32'd1, 16'd25, 1'b0);
    e2  = exp_rec(16'd13, 32'd1, 16'd25);
    el2 = model_lost(16'd13, 32'd1);
    check("pend_ready", dataIn_ready, 1'b0);
    check("pend_hold", dataOut, held);
    @(negedge clk); dataOut_ready = 1'b1;
    @(posedge clk); #1; dataOut_ready = 1'b0;
    check("m2_val", dataOut_val, 1'b1);
    check("m2_rec", dataOut, e2);
    check("m2_lost", packetLost, el2);
    check("m2_cnt", dataOut[48:55], 8'h11);
    check("m2_tail", dataOut[184:191], 8'h0D);
    check("m2_ready", dataIn_ready, 1'b1);
    consume();
    check("drain_val", dataOut_val, 1'b0);

    // truncation and sequence gap
    send_msg(16'd14, 32'd3, 16'd39, 1'b0);
    expect_rec("m3", 16'd14, 32'd3, 16'd39);
    check("m3_cnt", dataOut[48:55], 8'h1E);
    check("m3_ready", dataIn_ready, 1'b1);
    consume();
    send_msg(16'd14, 32'd4, 16'd44, 1'b0);
    expect_rec("m4", 16'd14, 32'd4, 16'd44);
    consume();
    send_msg(16'd14, 32'd6, 16'd12, 1'b0);
    expect_rec("m5", 16'd14, 32'd6, 16'd12);
    check("m5_cnt", dataOut[48:55], 8'h04);
    check("m5_lost", packetLost, 1'b1);
    consume();

    // empty payload and sequence wrap
    send_msg(16'd5, 32'hFFFF_FFFF, 16'd8, 1'b1);
    expect_rec("wrap_a", 16'd5, 32'hFFFF_FFFF, 16'd8);
    consume();
    send_msg(16'd5, 32'd0, 16'd9, 1'b1);
    expect_rec("wrap_b", 16'd5, 32'd0, 16'd9);
    consume();

    // malformed: short length, then a single-word message; neither touches the table
    send_msg(16'd14, 32'd100, 16'd6, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("bad_len_val", dataOut_val, 1'b0);
    send_word({8'd20, 8'd0, 8'd14, 8'd0}, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("bad_short_val", dataOut_val, 1'b0);
    send_msg(16'd14, 32'd7, 16'd16, 1'b1);
    expect_rec("after_bad", 16'd14, 32'd7, 16'd16);
    consume();

    // reset mid-payload with a valid record still held
    send_msg(16'd3, 32'd1, 16'd12, 1'b1);
    expect_rec("pre_rst", 16'd3, 32'd1, 16'd12);
    send_word({8'd20, 8'd0, 8'd3, 8'd0}, 1'b0);
    send_word({8'd2, 8'd0, 8'd0, 8'd0}, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_val", dataOut_val, 1'b0);
    check("mid_rst_out", dataOut, '0);
    check("mid_rst_ready", dataIn_ready, 1'b1);
    @(negedge clk); reset_b = 1'b0;
    seen.delete();
    send_msg(16'd3, 32'd9, 16'd16, 1'b1);
    expect_rec("post_rst", 16'd3, 32'd9, 16'd16);
    consume();

    // randomized messages with input gaps
    gaps = 1'b1;
    for (int n = 0; n < 60; n++) begin
      s = 16'($urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) l = 16'($urandom_range(0, 7));
      else l = 16'($urandom_range(8, 60));
      if (seen.exists(int'(s)) && $urandom_range(0, 2) != 0) q = seen[int'(s)] + 32'd1;
      else q = $urandom;
      send_msg(s, q, l, 1'b1);
      if (l < 16'd8) begin
        #1;
        check("rnd_bad_val", dataOut_val, 1'b0);
      end else begin
        expect_rec("rnd", s, q, l);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        consume();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
